// File: rtl/synth_pkg.sv
// Shared constants and FSM encoding for the voice allocator slice.
package synth_pkg;

  localparam int NUM_VOICES = 16;
  localparam int NOTE_W     = 7;
  localparam int AGE_W      = 4;
  localparam int IDX_W      = $clog2(NUM_VOICES);

  localparam logic [AGE_W-1:0] AGE_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/voice_slot.sv
// One oscillator slot: holds the note, gate and age of a single voice.
// Control priority: clear (panic) > assign > release / age increment.
module voice_slot
  import synth_pkg::*;
(
  input  logic              clock48kHz,
  input  logic              reset_n,
  input  logic              do_assign,
  input  logic              do_release,
  input  logic              age_inc,
  input  logic              clear,
  input  logic [NOTE_W-1:0] note_in,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic [AGE_W-1:0]  age
);

  // Slot registers; note is kept on clear/release so the release tail keeps its pitch.
  always_ff @(posedge clock48kHz or negedge reset_n) begin
    if (!reset_n) begin
      note <= '0;
      gate <= 1'b0;
      age  <= '0;
    end else if (clear) begin
      gate <= 1'b0;
      age  <= '0;
    end else if (do_assign) begin
      note <= note_in;
      gate <= 1'b1;
      age  <= '0;
    end else begin
      if (do_release) gate <= 1'b0;
      if (age_inc && (age != AGE_MAX)) age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: takes note-on/off events and maps them onto
// NUM_VOICES oscillator slots, stealing the oldest slot when all are busy.
//
// Event handshake: an event transfers on a rising edge where ev_valid and
// ev_ready are both high. ev_ready is high only in IDLE with panic low, so one
// event is in flight at a time; ev_on/ev_note are sampled only on that edge.
module voice_allocator
  import synth_pkg::*;
(
  input  logic                         clock48kHz,
  input  logic                         reset_n,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic                         panic,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic                         steal_pulse
);

  state_t state, next_state;

  logic [IDX_W-1:0]  idx;
  logic              ev_on_q;
  logic [NOTE_W-1:0] ev_note_q;

  logic              match_found, free_found, old_found;
  logic [IDX_W-1:0]  match_idx, free_idx, old_idx;
  logic [AGE_W-1:0]  old_age;

  logic [NOTE_W-1:0] slot_note [NUM_VOICES];
  logic [AGE_W-1:0]  slot_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] slot_gate;

  logic [NUM_VOICES-1:0] slot_assign, slot_release, slot_age_inc;
  logic [IDX_W-1:0]  target_idx;
  logic              steal_now;
  logic              accept;

  logic              cur_gate;
  logic [NOTE_W-1:0] cur_note;
  logic [AGE_W-1:0]  cur_age;

  assign ev_ready = (state == IDLE) && !panic;
  assign accept   = ev_valid && ev_ready;

  assign cur_gate = slot_gate[idx];
  assign cur_note = slot_note[idx];
  assign cur_age  = slot_age[idx];

  // FSM state register.
  always_ff @(posedge clock48kHz or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; panic returns to IDLE from any state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SCAN;
      SCAN:    if (idx == LAST_IDX) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (panic) next_state = IDLE;
  end

  // Commit decoding: pick the note-on target and drive per-slot controls.
  always_comb begin
    slot_assign  = '0;
    slot_release = '0;
    slot_age_inc = '0;
    steal_now    = 1'b0;
    target_idx   = old_idx;
    if (match_found)     target_idx = match_idx;
    else if (free_found) target_idx = free_idx;
    if ((state == COMMIT) && !panic) begin
      if (ev_on_q) begin
        steal_now = !match_found && !free_found;
        for (int i = 0; i < NUM_VOICES; i++) begin
          slot_assign[i]  = (target_idx == IDX_W'(i));
          slot_age_inc[i] = slot_gate[i] && (target_idx != IDX_W'(i));
        end
      end else begin
        for (int i = 0; i < NUM_VOICES; i++)
          slot_release[i] = slot_gate[i] && (slot_note[i] == ev_note_q);
      end
    end
  end

  // Event latch, scan index, scan trackers and the registered steal pulse.
  always_ff @(posedge clock48kHz or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      steal_pulse <= 1'b0;
    end else begin
      steal_pulse <= steal_now;
      if ((state == IDLE) && accept) begin
        ev_on_q     <= ev_on;
        ev_note_q   <= ev_note;
        idx         <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
        old_found   <= 1'b0;
        match_idx   <= '0;
        free_idx    <= '0;
        old_idx     <= '0;
        old_age     <= '0;
      end else if (state == SCAN) begin
        idx <= idx + 1'b1;
        if (!match_found && cur_gate && (cur_note == ev_note_q)) begin
          match_found <= 1'b1;
          match_idx   <= idx;
        end
        if (!free_found && !cur_gate) begin
          free_found <= 1'b1;
          free_idx   <= idx;
        end
        // Strict greater-than keeps the lowest index on equal ages.
        if (cur_gate && (!old_found || (cur_age > old_age))) begin
          old_found <= 1'b1;
          old_idx   <= idx;
          old_age   <= cur_age;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot u_slot (
      .clock48kHz (clock48kHz),
      .reset_n    (reset_n),
      .do_assign  (slot_assign[i]),
      .do_release (slot_release[i]),
      .age_inc    (slot_age_inc[i]),
      .clear      (panic),
      .note_in    (ev_note_q),
      .note       (slot_note[i]),
      .gate       (slot_gate[i]),
      .age        (slot_age[i])
    );
    assign voice_note[i*NOTE_W +: NOTE_W] = slot_note[i];
  end

  assign voice_gate = slot_gate;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: a table of note events with
// hand-computed expected gates/notes/steal, plus directed multi-cycle sequences
// for latency, panic and asynchronous reset.
module tb_voice_allocator;

  localparam int NV = 16;
  localparam int NW = 7;

  logic              clock48kHz;
  logic              reset_n;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NW-1:0]     ev_note;
  logic              panic;
  logic [NV*NW-1:0]  voice_note;
  logic [NV-1:0]     voice_gate;
  logic              steal_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;

  voice_allocator dut (
    .clock48kHz  (clock48kHz),
    .reset_n     (reset_n),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_on       (ev_on),
    .ev_note     (ev_note),
    .panic       (panic),
    .voice_note  (voice_note),
    .voice_gate  (voice_gate),
    .steal_pulse (steal_pulse)
  );

  // Clock and reset
  initial clock48kHz = 1'b0;
  always #5 clock48kHz = ~clock48kHz;

  typedef struct {
    logic          rst;
    logic          on;
    logic [NW-1:0] note;
    logic [NV-1:0] exp_gate;
    logic          exp_steal;
    int            slot;
    logic [NW-1:0] exp_note;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clock48kHz);
    reset_n  = 1'b0;
    ev_valid = 1'b0;
    panic    = 1'b0;
    @(negedge clock48kHz);
    @(negedge clock48kHz);
    reset_n = 1'b1;
  endtask

  // Drives one event, then waits until just after the edge that commits it.
  task automatic send_event(input logic on, input logic [NW-1:0] note);
    int waited = 0;
    while (!ev_ready && waited < 40) begin
      @(negedge clock48kHz);
      waited++;
    end
    check("ev_ready_wait", ev_ready, 1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    @(posedge clock48kHz);
    #1;
    ev_valid = 1'b0;
    ev_on    = ~on;
    ev_note  = note ^ 7'h55;
    repeat (NV + 1) @(posedge clock48kHz);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic on, input logic [NW-1:0] note,
                              input logic [NV-1:0] g, input logic s, input int slot,
                              input logic [NW-1:0] n);
    vec_t v;
    v.rst = rst; v.on = on; v.note = note; v.exp_gate = g;
    v.exp_steal = s; v.slot = slot; v.exp_note = n;
    return v;
  endfunction

  initial begin
    logic [NV*NW-1:0] exp_vec;
    logic             gate_before;
    int               low;

    reset_n  = 1'b0;
    ev_valid = 1'b0;
    ev_on    = 1'b0;
    ev_note  = '0;
    panic    = 1'b0;

    // Vector table
    vecs.push_back(mk(1, 1, 60, 16'h0001, 0, 0, 60));
    vecs.push_back(mk(1, 1, 60, 16'h0001, 0, 0, 60));
    vecs.push_back(mk(0, 1, 64, 16'h0003, 0, 1, 64));
    vecs.push_back(mk(0, 1, 67, 16'h0007, 0, 2, 67));
    vecs.push_back(mk(0, 0, 64, 16'h0005, 0, 1, 64));
    for (int k = 0; k < NV; k++)
      vecs.push_back(mk(k == 0, 1, NW'(40 + k), NV'((32'd1 << (k + 1)) - 1), 0, k, NW'(40 + k)));
    vecs.push_back(mk(0, 1, 70, 16'hFFFF, 1, 0, 70));
    vecs.push_back(mk(0, 1, 70, 16'hFFFF, 0, 1, 41));
    vecs.push_back(mk(1, 1, 60, 16'h0001, 0, 0, 60));
    vecs.push_back(mk(0, 1, 62, 16'h0003, 0, 1, 62));
    vecs.push_back(mk(0, 1, 60, 16'h0003, 0, 0, 60));
    // Slot1 is older than the retriggered slot0, so the steal lands on slot1.
    for (int k = 0; k < 14; k++)
      vecs.push_back(mk(0, 1, NW'(80 + k), NV'((32'd1 << (k + 3)) - 1), 0, k + 2, NW'(80 + k)));
    vecs.push_back(mk(0, 1, 100, 16'hFFFF, 1, 1, 100));
    vecs.push_back(mk(0, 0, 5, 16'hFFFF, 0, 1, 100));
    vecs.push_back(mk(0, 0, 100, 16'hFFFD, 0, 1, 100));

    // Reset state
    do_reset();
    #1;
    check("rst_gate", voice_gate, 0);
    check("rst_note", voice_note, 0);
    check("rst_steal", steal_pulse, 0);
    check("rst_ready", ev_ready, 1);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      send_event(vecs[k].on, vecs[k].note);
      check($sformatf("v%0d_gate", k), voice_gate, vecs[k].exp_gate);
      check($sformatf("v%0d_steal", k), steal_pulse, vecs[k].exp_steal);
      check($sformatf("v%0d_note", k), voice_note[vecs[k].slot*NW +: NW], vecs[k].exp_note);
      if (vecs[k].exp_steal) begin
        @(posedge clock48kHz);
        #1;
        check($sformatf("v%0d_steal_drop", k), steal_pulse, 0);
      end
    end

    // Latency and ready timing; ev_note changes after acceptance are ignored.
    do_reset();
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 60;
    @(posedge clock48kHz);
    #1;
    ev_valid = 1'b0; ev_note = 99;
    low = 0;
    gate_before = 1'b1;
    for (int i = 0; i < NV + 1; i++) begin
      if (!ev_ready) low++;
      if (i == NV) gate_before = voice_gate[0];
      @(posedge clock48kHz);
      #1;
    end
    check("lat_ready_low_cycles", low, NV + 1);
    check("lat_no_early_write", gate_before, 0);
    check("lat_gate", voice_gate, 16'h0001);
    check("lat_note_sampled", voice_note[NW-1:0], 60);
    check("lat_ready_back", ev_ready, 1);

    // Panic during SCAN of a note-on 72.
    do_reset();
    send_event(1, 10);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 72;
    @(posedge clock48kHz);
    #1;
    repeat (4) @(posedge clock48kHz);
    @(negedge clock48kHz);
    panic = 1'b1;
    #1;
    check("panic_ready_low", ev_ready, 0);
    @(posedge clock48kHz);
    #1;
    check("panic_gates_clear", voice_gate, 0);
    repeat (3) @(posedge clock48kHz);
    #1;
    check("panic_ready_held_low", ev_ready, 0);
    @(negedge clock48kHz);
    panic = 1'b0;
    ev_valid = 1'b0;
    #1;
    check("panic_ready_release", ev_ready, 1);
    repeat (20) @(posedge clock48kHz);
    #1;
    exp_vec = '0;
    exp_vec[NW-1:0] = 10;
    check("panic_note_kept", voice_note, exp_vec);
    check("panic_gates_stay", voice_gate, 0);
    check("panic_steal", steal_pulse, 0);

    // Asynchronous reset in the COMMIT cycle.
    do_reset();
    send_event(1, 20);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 21;
    @(posedge clock48kHz);
    #1;
    ev_valid = 1'b0;
    repeat (NV) @(posedge clock48kHz);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_gate", voice_gate, 0);
    check("arst_note", voice_note, 0);
    check("arst_steal", steal_pulse, 0);
    @(negedge clock48kHz);
    reset_n = 1'b1;
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 33;
    @(posedge clock48kHz);
    #1;
    check("arst_first_accept", ev_ready, 0);
    ev_valid = 1'b0;
    repeat (NV + 1) @(posedge clock48kHz);
    #1;
    check("arst_post_gate", voice_gate, 16'h0001);
    check("arst_post_note", voice_note[NW-1:0], 33);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
